// File: rtl/free_list_pkg.sv
// free_list_pkg: shared system defines (N_WAY, N_ROB, N_PR, N_ARCH_REG, CDB_BITS, ZERO_REG_PR)
// plus the tag type and push-slot sizing derived from them.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH
`define N_WAY 2
`define N_ROB 8
`define N_PR 64
`define N_ARCH_REG 32
`define CDB_BITS $clog2(`N_PR)
`define ZERO_REG_PR 0
`endif

package free_list_pkg;
  localparam int N_WAY = `N_WAY;
  localparam int N_ROB = `N_ROB;
  localparam int N_PR_DEF = `N_PR;
  localparam int N_ARCH_DEF = `N_ARCH_REG;
  localparam int CDB_BITS = `CDB_BITS;
  localparam int ZERO_REG_PR = `ZERO_REG_PR;
  localparam int N_PUSH = N_WAY + N_ROB;
  localparam int PCW = $clog2(N_PUSH + 1);
  typedef logic [CDB_BITS-1:0] tag_t;
  localparam tag_t ZERO_TAG = tag_t'(ZERO_REG_PR);
endpackage

// File: rtl/fl_push_compact.sv
// fl_push_compact: packs the valid push tags in slot order and counts them.
module fl_push_compact
  import free_list_pkg::*;
(
  input  logic [N_PUSH-1:0] valid,
  input  tag_t [N_PUSH-1:0] tags,
  output tag_t [N_PUSH-1:0] list,
  output logic [PCW-1:0]    count
);
  always_comb begin
    list = '0;
    count = '0;
    for (int i = 0; i < N_PUSH; i++)
      if (valid[i]) begin
        list[count] = tags[i];
        count = count + PCW'(1);
      end
  end
endmodule

// File: rtl/free_list.sv
// free_list: circular free physical-register queue with prefix allocation and compacted frees.
// Define FREE_LIST_DUP_CHECK_EN to add an is_free bitmap that drops duplicate frees.
module free_list
  import free_list_pkg::*;
#(
  parameter int N_PR = N_PR_DEF,
  parameter int N_ARCH = N_ARCH_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [N_WAY-1:0]       retire_valid,
  input  tag_t [N_WAY-1:0]       retire_told,
  input  logic                   branch_haz,
  input  tag_t [N_ROB-1:0]       free_list_haz,
  input  logic [N_WAY-1:0]       alloc_req,
  output tag_t [N_WAY-1:0]       free_tag,
  output logic [N_WAY-1:0]       free_valid,
  output logic [CDB_BITS:0]      num_free,
  output logic [$clog2(N_WAY):0] free_avail,
  output logic                   dup_err
);
  localparam int CW = CDB_BITS + 1;
  localparam int AW = $clog2(N_WAY) + 1;
  tag_t [N_PR-1:0] mem;
  tag_t head, tail, t;
  logic [CW-1:0] pops, occ;
  logic [N_PUSH-1:0] push_valid;
  tag_t [N_PUSH-1:0] push_tags, push_list, acc_list;
  logic [PCW-1:0] push_cnt, acc_cnt;
  logic ok, dup;
`ifdef FREE_LIST_DUP_CHECK_EN
  logic [N_PR-1:0] is_free, free_n;
`endif

  always_comb begin
    push_valid = '0;
    push_tags = '0;
    for (int i = 0; i < N_WAY; i++) begin
      push_valid[i] = retire_valid[i] && retire_told[i] != ZERO_TAG;
      push_tags[i] = retire_told[i];
    end
    for (int j = 0; j < N_ROB; j++) begin
      push_valid[N_WAY+j] = branch_haz && free_list_haz[j] != '0 && free_list_haz[j] != ZERO_TAG;
      push_tags[N_WAY+j] = free_list_haz[j];
    end
  end

  fl_push_compact u_compact (
    .valid (push_valid),
    .tags  (push_tags),
    .list  (push_list),
    .count (push_cnt)
  );

  always_comb begin
    free_tag = '0;
    free_valid = '0;
    for (int i = 0; i < N_WAY; i++) begin
      free_tag[i] = mem[head + CDB_BITS'(i)];
      free_valid[i] = num_free > CW'(i);
    end
    free_avail = num_free >= CW'(N_WAY) ? AW'(N_WAY) : num_free[AW-1:0];
  end

  // Pops first, then pushes in compacted order against the post-pop occupancy.
  always_comb begin
    ok = !branch_haz;
    pops = '0;
    for (int i = 0; i < N_WAY; i++) begin
      ok = ok && alloc_req[i] && free_valid[i];
      if (ok) pops = CW'(i + 1);
    end
    occ = num_free - pops;
    acc_list = '0;
    acc_cnt = '0;
    dup = 1'b0;
    t = '0;
`ifdef FREE_LIST_DUP_CHECK_EN
    free_n = is_free;
    for (int i = 0; i < N_WAY; i++)
      if (CW'(i) < pops) free_n[free_tag[i]] = 1'b0;
`endif
    for (int k = 0; k < N_PUSH; k++)
      if (PCW'(k) < push_cnt) begin
        t = push_list[k];
        if (occ == CW'(N_PR)
`ifdef FREE_LIST_DUP_CHECK_EN
            || free_n[t]
`endif
           ) dup = 1'b1;
        else begin
          acc_list[acc_cnt] = t;
          acc_cnt = acc_cnt + PCW'(1);
          occ = occ + CW'(1);
`ifdef FREE_LIST_DUP_CHECK_EN
          free_n[t] = 1'b1;
`endif
        end
      end
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      for (int k = 0; k < N_PR; k++) mem[k] <= k < N_PR - N_ARCH ? tag_t'(N_ARCH + k) : '0;
      head <= '0;
      tail <= tag_t'(N_PR - N_ARCH);
      num_free <= CW'(N_PR - N_ARCH);
      dup_err <= 1'b0;
    end else begin
      for (int k = 0; k < N_PUSH; k++)
        if (PCW'(k) < acc_cnt) mem[tail + CDB_BITS'(k)] <= acc_list[k];
      head <= head + pops[CDB_BITS-1:0];
      tail <= tail + CDB_BITS'(acc_cnt);
      num_free <= num_free - pops + CW'(acc_cnt);
      dup_err <= dup_err | dup;
    end

`ifdef FREE_LIST_DUP_CHECK_EN
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) for (int k = 0; k < N_PR; k++) is_free[k] <= k >= N_ARCH;
    else is_free <= free_n;
`endif
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed and randomized checks of free_list against a queue-based model.
module tb_free_list;
  import free_list_pkg::*;
  localparam int NPR = 64;
  localparam int NARCH = 32;
`ifdef FREE_LIST_DUP_CHECK_EN
  localparam bit DUP = 1'b1;
`else
  localparam bit DUP = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [N_WAY-1:0] retire_valid, alloc_req, free_valid;
  tag_t [N_WAY-1:0] retire_told, free_tag;
  logic branch_haz;
  tag_t [N_ROB-1:0] free_list_haz;
  logic [CDB_BITS:0] num_free;
  logic [$clog2(N_WAY):0] free_avail;
  logic dup_err;
  int total = 0, bad = 0;
  int q[$];
  bit isf[NPR];
  bit m_dup;

  always #5 clock = ~clock;

  free_list #(.N_PR(NPR), .N_ARCH(NARCH)) dut (
    .clock(clock), .reset_n(reset_n), .retire_valid(retire_valid), .retire_told(retire_told),
    .branch_haz(branch_haz), .free_list_haz(free_list_haz), .alloc_req(alloc_req),
    .free_tag(free_tag), .free_valid(free_valid), .num_free(num_free),
    .free_avail(free_avail), .dup_err(dup_err)
  );

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < NPR; k++) isf[k] = k >= NARCH;
    for (int k = NARCH; k < NPR; k++) q.push_back(k);
    m_dup = 1'b0;
  endtask

  // Allocations pop a prefix of the queue; frees append, dropped when full or already free.
  task automatic model_step();
    int n;
    bit ok;
    int p[$];
    n = 0;
    ok = !branch_haz;
    for (int i = 0; i < N_WAY; i++) begin
      ok = ok && alloc_req[i] && q.size() > i;
      if (ok) n = i + 1;
    end
    repeat (n) isf[q.pop_front()] = 1'b0;
    for (int i = 0; i < N_WAY; i++)
      if (retire_valid[i] && int'(retire_told[i]) != ZERO_REG_PR) p.push_back(int'(retire_told[i]));
    if (branch_haz)
      for (int j = 0; j < N_ROB; j++)
        if (free_list_haz[j] != '0 && int'(free_list_haz[j]) != ZERO_REG_PR) p.push_back(int'(free_list_haz[j]));
    foreach (p[k])
      if (q.size() >= NPR || (DUP && isf[p[k]])) m_dup = 1'b1;
      else begin
        q.push_back(p[k]);
        isf[p[k]] = 1'b1;
      end
  endtask

  task automatic idle();
    retire_valid = '0; retire_told = '0; branch_haz = 1'b0; free_list_haz = '0; alloc_req = '0;
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    total++; if (num_free !== 7'd32) begin bad++; $display("FAIL rst_hold_num_free got=%0d exp=32", num_free); end
    total++; if (dup_err !== 1'b0) begin bad++; $display("FAIL rst_hold_dup got=%0b exp=0", dup_err); end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    total++; if (free_tag[0] !== 6'd32 || free_tag[1] !== 6'd33) begin bad++; $display("FAIL rst_tags got=%0d,%0d exp=32,33", free_tag[0], free_tag[1]); end
    total++; if (free_valid !== 2'b11) begin bad++; $display("FAIL rst_valid got=%b exp=11", free_valid); end
    total++; if (num_free !== 7'd32) begin bad++; $display("FAIL rst_num_free got=%0d exp=32", num_free); end
    total++; if (free_avail !== 2'd2) begin bad++; $display("FAIL rst_avail got=%0d exp=2", free_avail); end
  endtask

  task automatic test_alloc();
    alloc_req = 2'b11;
    step();
    alloc_req = 2'b00;
    total++; if (free_tag[0] !== 6'd34 || free_tag[1] !== 6'd35) begin bad++; $display("FAIL alloc_tags got=%0d,%0d exp=34,35", free_tag[0], free_tag[1]); end
    total++; if (num_free !== 7'd30) begin bad++; $display("FAIL alloc_num_free got=%0d exp=30", num_free); end
    alloc_req = 2'b10;
    step();
    alloc_req = 2'b00;
    total++; if (num_free !== 7'd30 || free_tag[0] !== 6'd34) begin bad++; $display("FAIL alloc_nonprefix got=%0d/%0d exp=30/34", num_free, free_tag[0]); end
  endtask

  task automatic test_retire();
    retire_valid = 2'b11;
    retire_told[0] = 6'd5;
    retire_told[1] = 6'd0;
    step();
    idle();
    total++; if (num_free !== 7'd31) begin bad++; $display("FAIL retire_num_free got=%0d exp=31", num_free); end
    alloc_req = 2'b11;
    repeat (15) step();
    idle();
    total++; if (free_tag[0] !== 6'd5) begin bad++; $display("FAIL retire_wrap_tag got=%0d exp=5", free_tag[0]); end
    total++; if (num_free !== 7'd1) begin bad++; $display("FAIL retire_drain_num got=%0d exp=1", num_free); end
  endtask

  task automatic test_branch();
    branch_haz = 1'b1;
    alloc_req = 2'b11;
    retire_valid = 2'b01;
    retire_told[0] = 6'd7;
    retire_told[1] = 6'd9;
    free_list_haz[0] = 6'd40;
    free_list_haz[1] = 6'd41;
    step();
    idle();
    total++; if (num_free !== 7'd4) begin bad++; $display("FAIL branch_num_free got=%0d exp=4", num_free); end
    total++; if (free_tag[0] !== 6'd5 || free_tag[1] !== 6'd7) begin bad++; $display("FAIL branch_head got=%0d,%0d exp=5,7", free_tag[0], free_tag[1]); end
    alloc_req = 2'b11;
    step();
    idle();
    total++; if (free_tag[0] !== 6'd40 || free_tag[1] !== 6'd41) begin bad++; $display("FAIL branch_order got=%0d,%0d exp=40,41", free_tag[0], free_tag[1]); end
  endtask

  task automatic test_empty();
    alloc_req = 2'b01;
    step();
    idle();
    total++; if (free_valid !== 2'b01 || free_avail !== 2'd1) begin bad++; $display("FAIL one_left got=%b/%0d exp=01/1", free_valid, free_avail); end
    alloc_req = 2'b11;
    step();
    total++; if (free_valid !== 2'b00 || num_free !== 7'd0 || free_avail !== 2'd0) begin bad++; $display("FAIL empty got=%b/%0d/%0d exp=00/0/0", free_valid, num_free, free_avail); end
    step();
    total++; if (num_free !== 7'd0) begin bad++; $display("FAIL empty_alloc got=%0d exp=0", num_free); end
    retire_valid = 2'b01;
    retire_told[0] = 6'd9;
    step();
    idle();
    total++; if (num_free !== 7'd1 || free_tag[0] !== 6'd9) begin bad++; $display("FAIL no_bypass got=%0d/%0d exp=1/9", num_free, free_tag[0]); end
  endtask

`ifdef FREE_LIST_DUP_CHECK_EN
  task automatic test_dup();
    retire_valid = 2'b01;
    retire_told[0] = 6'd40;
    step();
    total++; if (num_free !== 7'd2 || dup_err !== 1'b0) begin bad++; $display("FAIL dup_first got=%0d/%0b exp=2/0", num_free, dup_err); end
    step();
    idle();
    total++; if (num_free !== 7'd2 || dup_err !== 1'b1) begin bad++; $display("FAIL dup_second got=%0d/%0b exp=2/1", num_free, dup_err); end
    repeat (3) step();
    total++; if (dup_err !== 1'b1) begin bad++; $display("FAIL dup_sticky got=%0b exp=1", dup_err); end
  endtask
`else
  task automatic test_full();
    branch_haz = 1'b1;
    alloc_req = 2'b11;
    retire_valid = 2'b11;
    for (int c = 0; c < 7; c++) begin
      for (int k = 0; k < N_PUSH; k++) begin
        if (k < N_WAY) retire_told[k] = tag_t'(1 + (c * 10 + k) % 63);
        else free_list_haz[k-N_WAY] = tag_t'(1 + (c * 10 + k) % 63);
      end
      step();
      if (c == 5) begin
        total++; if (num_free !== 7'd61 || dup_err !== 1'b0) begin bad++; $display("FAIL fill got=%0d/%0b exp=61/0", num_free, dup_err); end
      end
    end
    idle();
    total++; if (num_free !== 7'd64 || dup_err !== 1'b1) begin bad++; $display("FAIL overflow got=%0d/%0b exp=64/1", num_free, dup_err); end
    total++; if (free_tag[0] !== 6'd9 || free_valid !== 2'b11) begin bad++; $display("FAIL full_head got=%0d/%b exp=9/11", free_tag[0], free_valid); end
    alloc_req = 2'b11;
    step();
    idle();
    total++; if (num_free !== 7'd62 || free_tag[0] !== 6'd2) begin bad++; $display("FAIL full_pop got=%0d/%0d exp=62/2", num_free, free_tag[0]); end
  endtask
`endif

  task automatic test_reset_mid();
    alloc_req = 2'b11;
    retire_valid = 2'b01;
    retire_told[0] = 6'd3;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    total++; if (num_free !== 7'd32 || dup_err !== 1'b0) begin bad++; $display("FAIL mid_rst got=%0d/%0b exp=32/0", num_free, dup_err); end
    total++; if (free_tag[0] !== 6'd32 || free_tag[1] !== 6'd33) begin bad++; $display("FAIL mid_rst_tags got=%0d,%0d exp=32,33", free_tag[0], free_tag[1]); end
    @(posedge clock);
    @(negedge clock);
    idle();
    reset_n = 1'b1;
    #1;
    total++; if (num_free !== 7'd32) begin bad++; $display("FAIL mid_rst_release got=%0d exp=32", num_free); end
  endtask

  task automatic test_random();
    bit hi;
    for (int c = 0; c < 600; c++) begin
      hi = (c % 200) >= 100;
      alloc_req = ($urandom_range(0, 3) != 0) ? 2'b11 : N_WAY'($urandom);
      for (int i = 0; i < N_WAY; i++) begin
        retire_valid[i] = $urandom_range(0, 3) < (hi ? 3 : 1);
        retire_told[i] = tag_t'($urandom);
      end
      branch_haz = $urandom_range(0, 7) == 0;
      for (int j = 0; j < N_ROB; j++) free_list_haz[j] = ($urandom_range(0, 2) == 0) ? '0 : tag_t'($urandom);
      step();
      total++; if (int'(num_free) !== q.size()) begin bad++; $display("FAIL rnd_num_free c=%0d got=%0d exp=%0d", c, num_free, q.size()); end
      total++; if (dup_err !== m_dup) begin bad++; $display("FAIL rnd_dup c=%0d got=%0b exp=%0b", c, dup_err, m_dup); end
      total++; if (int'(free_avail) !== (q.size() >= N_WAY ? N_WAY : q.size())) begin bad++; $display("FAIL rnd_avail c=%0d got=%0d size=%0d", c, free_avail, q.size()); end
      for (int i = 0; i < N_WAY; i++) begin
        total++; if (free_valid[i] !== (q.size() > i)) begin bad++; $display("FAIL rnd_valid c=%0d way=%0d got=%0b size=%0d", c, i, free_valid[i], q.size()); end
        if (i < q.size()) begin
          total++; if (free_tag[i] !== tag_t'(q[i])) begin bad++; $display("FAIL rnd_tag c=%0d way=%0d got=%0d exp=%0d", c, i, free_tag[i], q[i]); end
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_retire();
    test_branch();
    test_empty();
`ifdef FREE_LIST_DUP_CHECK_EN
    test_dup();
`else
    test_full();
`endif
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
